// File: rtl/settle_mon.sv
// settle_mon: multi-channel settling / convergence checker.
// Watches NUM_CH signed sample streams against a programmed target band and
// reports, per channel, whether and when the stream settled within a timeout
// and how many out-of-band excursions followed settling.
module settle_mon #(
    parameter int NUM_CH     = 2,
    parameter int WIDTH      = 16,
    parameter int DWELL_W    = 12,
    parameter int TMO_W      = 24,
    parameter int GLT_W      = 8,
    parameter int MAX_GLITCH = 0,
    parameter int EARLY_EXIT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [WIDTH-1:0]        target,
    input  logic [WIDTH-1:0]        tol,
    input  logic [DWELL_W-1:0]      dwell,
    input  logic [TMO_W-1:0]        timeout,
    input  logic [NUM_CH*WIDTH-1:0] sample,
    input  logic                    sample_vld,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_CH-1:0]       settled,
    output logic [NUM_CH-1:0]       pass,
    output logic [NUM_CH*TMO_W-1:0] settle_time,
    output logic [NUM_CH*GLT_W-1:0] glitch_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [DWELL_W-1:0] DW_ONE  = DWELL_W'(1);
    localparam logic [DWELL_W:0]   DWX_ONE = (DWELL_W+1)'(1);
    localparam logic [TMO_W-1:0]   T_ONE   = TMO_W'(1);
    localparam logic [GLT_W-1:0]   G_ONE   = GLT_W'(1);
    localparam logic [WIDTH:0]     M_ONE   = (WIDTH+1)'(1);

    logic [1:0]                r_state;
    logic                      r_done;
    logic [WIDTH-1:0]          r_target;
    logic [WIDTH-1:0]          r_tol;
    logic [DWELL_W-1:0]        r_dwell;
    logic [TMO_W-1:0]          r_timeout;
    logic [TMO_W-1:0]          r_elapsed;
    logic [DWELL_W-1:0]        r_run_cnt   [NUM_CH];
    logic [TMO_W-1:0]          r_run_start [NUM_CH];
    logic [NUM_CH-1:0]         r_settled;
    logic [NUM_CH*TMO_W-1:0]   r_settle_time;
    logic [NUM_CH*GLT_W-1:0]   r_glitch;

    logic                      w_eval;
    logic [WIDTH:0]            w_diff [NUM_CH];
    logic [WIDTH:0]            w_mag  [NUM_CH];
    logic [NUM_CH-1:0]         w_in_band;
    logic [NUM_CH-1:0]         w_hit;
    logic [NUM_CH-1:0]         w_settled_nxt;
    logic                      w_last;
    logic                      w_finish;

    // Band test per channel (WIDTH+1-bit difference so no overflow) and the run-exit decision.
    always_comb begin
        w_eval = (r_state == S_RUN) && sample_vld;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            w_diff[ch]    = {sample[ch*WIDTH + WIDTH - 1], sample[ch*WIDTH +: WIDTH]}
                          - {r_target[WIDTH-1], r_target};
            w_mag[ch]     = w_diff[ch][WIDTH] ? (~w_diff[ch] + M_ONE) : w_diff[ch];
            w_in_band[ch] = (w_mag[ch] <= {1'b0, r_tol});
            w_hit[ch]     = w_eval && !r_settled[ch] && w_in_band[ch]
                          && (({1'b0, r_run_cnt[ch]} + DWX_ONE) >= {1'b0, r_dwell});
        end
        w_settled_nxt = r_settled | w_hit;
        w_last        = (r_elapsed == (r_timeout - T_ONE));
        w_finish      = w_last || ((EARLY_EXIT != 0) && (&w_settled_nxt));
    end

    // Run-control FSM: config capture in ARM, elapsed count in RUN, one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_state   <= S_IDLE;
            r_done    <= 1'b0;
            r_target  <= '0;
            r_tol     <= '0;
            r_dwell   <= '0;
            r_timeout <= '0;
            r_elapsed <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_ARM;
                end
                S_ARM: begin
                    r_target  <= target;
                    r_tol     <= tol;
                    r_dwell   <= (dwell == '0) ? DW_ONE : dwell;
                    r_timeout <= (timeout == '0) ? T_ONE : timeout;
                    r_elapsed <= '0;
                    r_state   <= S_RUN;
                end
                S_RUN: begin
                    if (w_finish) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_elapsed <= r_elapsed + T_ONE;
                    end
                end
                S_DONE: begin
                    if (start) r_state <= S_ARM;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Per-channel dwell tracking before settling and glitch counting after it.
    always_ff @(posedge clk) begin
        if (rst || abort || (r_state == S_ARM)) begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                r_run_cnt[ch]   <= '0;
                r_run_start[ch] <= '0;
            end
            r_settled     <= '0;
            r_settle_time <= '0;
            r_glitch      <= '0;
        end else if (w_eval) begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                if (!r_settled[ch]) begin
                    if (w_in_band[ch]) begin
                        if (r_run_cnt[ch] == '0) r_run_start[ch] <= r_elapsed;
                        if (r_run_cnt[ch] != '1) r_run_cnt[ch] <= r_run_cnt[ch] + DW_ONE;
                        // A dwell of 1 settles on the first in-band sample, before run_start is written.
                        if (w_hit[ch]) begin
                            r_settled[ch] <= 1'b1;
                            r_settle_time[ch*TMO_W +: TMO_W] <=
                                (r_run_cnt[ch] == '0) ? r_elapsed : r_run_start[ch];
                        end
                    end else begin
                        r_run_cnt[ch] <= '0;
                    end
                end else if (!w_in_band[ch] && (r_glitch[ch*GLT_W +: GLT_W] != '1)) begin
                    r_glitch[ch*GLT_W +: GLT_W] <= r_glitch[ch*GLT_W +: GLT_W] + G_ONE;
                end
            end
        end
    end

    // Output decode: status flags and pass verdict from registered results.
    always_comb begin
        busy        = (r_state == S_ARM) || (r_state == S_RUN);
        done        = r_done;
        settled     = r_settled;
        settle_time = r_settle_time;
        glitch_cnt  = r_glitch;
        pass        = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            pass[ch] = r_settled[ch] && (32'(r_glitch[ch*GLT_W +: GLT_W]) <= MAX_GLITCH);
        end
    end

endmodule

// File: tb/tb_settle_mon.sv
// tb_settle_mon: randomized and directed bench for settle_mon. Two instances
// (early-exit and run-to-timeout) see identical stimulus; expected results come
// from a per-run reference model evaluated over the stored sample sequence.
module tb_settle_mon;

    localparam int NCH  = 2;
    localparam int W    = 16;
    localparam int DW   = 12;
    localparam int TW   = 24;
    localparam int GW   = 8;
    localparam int MAXN = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, start, abort, sample_vld;
    logic [W-1:0]       target, tol;
    logic [DW-1:0]      dwell;
    logic [TW-1:0]      timeout;
    logic [NCH*W-1:0]   sample;

    logic               busy_e, done_e, busy_n, done_n;
    logic [NCH-1:0]     settled_e, pass_e, settled_n, pass_n;
    logic [NCH*TW-1:0]  st_e, st_n;
    logic [NCH*GW-1:0]  gc_e, gc_n;

    settle_mon #(.NUM_CH(NCH), .WIDTH(W), .DWELL_W(DW), .TMO_W(TW), .GLT_W(GW),
                 .MAX_GLITCH(2), .EARLY_EXIT(1)) u_dut_e (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .target(target), .tol(tol),
        .dwell(dwell), .timeout(timeout), .sample(sample), .sample_vld(sample_vld),
        .busy(busy_e), .done(done_e), .settled(settled_e), .pass(pass_e),
        .settle_time(st_e), .glitch_cnt(gc_e));

    settle_mon #(.NUM_CH(NCH), .WIDTH(W), .DWELL_W(DW), .TMO_W(TW), .GLT_W(GW),
                 .MAX_GLITCH(0), .EARLY_EXIT(0)) u_dut_n (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .target(target), .tol(tol),
        .dwell(dwell), .timeout(timeout), .sample(sample), .sample_vld(sample_vld),
        .busy(busy_n), .done(done_n), .settled(settled_n), .pass(pass_n),
        .settle_time(st_n), .glitch_cnt(gc_n));

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] s_mem [NCH][MAXN];
    bit           v_mem [MAXN];

    int maxg [2] = '{2, 0};
    int exp_end  [2];
    bit exp_set  [2][NCH];
    bit exp_pass [2][NCH];
    int exp_st   [2][NCH];
    int exp_gc   [2][NCH];
    int got_done_k [2];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit inb(input int ch, input int k, input int tgt, input int tl);
        int d;
        d = int'($signed(s_mem[ch][k])) - tgt;
        if (d < 0) d = -d;
        return d <= tl;
    endfunction

    // Reference: first window of max(dwell,1) consecutive in-band valid samples settles a
    // channel; the run ends at timeout or, for early exit, at the latest channel settle.
    task automatic run_model(input int te, input int d, input int tgt, input int tl);
        int need, streak, s0, mx, last, gc;
        int settle_k [NCH];
        int start_k  [NCH];
        bit all_set;
        need = (d == 0) ? 1 : d;
        for (int ch = 0; ch < NCH; ch++) begin
            settle_k[ch] = -1;
            start_k[ch]  = 0;
            streak = 0;
            s0 = 0;
            for (int k = 0; k < te; k++) begin
                if (settle_k[ch] < 0 && v_mem[k]) begin
                    if (inb(ch, k, tgt, tl)) begin
                        if (streak == 0) s0 = k;
                        streak++;
                        if (streak >= need) begin
                            settle_k[ch] = k;
                            start_k[ch]  = s0;
                        end
                    end else begin
                        streak = 0;
                    end
                end
            end
        end
        for (int e = 0; e < 2; e++) begin
            last = te - 1;
            if (e == 0) begin
                all_set = 1'b1;
                mx = 0;
                for (int ch = 0; ch < NCH; ch++) begin
                    if (settle_k[ch] < 0) all_set = 1'b0;
                    else if (settle_k[ch] > mx) mx = settle_k[ch];
                end
                if (all_set) last = mx;
            end
            exp_end[e] = last;
            for (int ch = 0; ch < NCH; ch++) begin
                exp_set[e][ch] = (settle_k[ch] >= 0);
                exp_st[e][ch]  = exp_set[e][ch] ? start_k[ch] : 0;
                gc = 0;
                if (exp_set[e][ch]) begin
                    for (int k = settle_k[ch] + 1; k <= last; k++) begin
                        if (v_mem[k] && !inb(ch, k, tgt, tl) && gc < 255) gc++;
                    end
                end
                exp_gc[e][ch]   = gc;
                exp_pass[e][ch] = exp_set[e][ch] && (gc <= maxg[e]);
            end
        end
    endtask

    task automatic arm(input int t, input int d, input logic [W-1:0] tgt, input logic [W-1:0] tl);
        target  = tgt;
        tol     = tl;
        dwell   = DW'(d);
        timeout = TW'(t);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tick();
        // Scramble config after ARM; the DUT must use its latched copy.
        target  = W'($urandom);
        tol     = W'($urandom);
        dwell   = DW'($urandom);
        timeout = TW'($urandom);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy_e"}, busy_e, 0);
        chk({tag, " busy_n"}, busy_n, 0);
        chk({tag, " done_e"}, done_e, 0);
        chk({tag, " done_n"}, done_n, 0);
        chk({tag, " settled_e"}, settled_e, 0);
        chk({tag, " settled_n"}, settled_n, 0);
        chk({tag, " pass_e"}, pass_e, 0);
        chk({tag, " pass_n"}, pass_n, 0);
        chk({tag, " st_e"}, st_e, 0);
        chk({tag, " st_n"}, st_n, 0);
        chk({tag, " gc_e"}, gc_e, 0);
        chk({tag, " gc_n"}, gc_n, 0);
    endtask

    task automatic do_run(input string name, input int t, input int d,
                          input logic [W-1:0] tgt, input logic [W-1:0] tl, input bit rnd_start);
        int te;
        int ndone [2];
        logic [NCH-1:0]    set_o, pass_o;
        logic [NCH*TW-1:0] st_o;
        logic [NCH*GW-1:0] gc_o;
        te = (t == 0) ? 1 : t;
        run_model(te, d, int'($signed(tgt)), int'(tl));
        arm(t, d, tgt, tl);
        chk({name, " busy at run"}, busy_e, 1);
        got_done_k = '{-1, -1};
        ndone = '{0, 0};
        for (int k = 0; k < te + 3; k++) begin
            if (k < te) begin
                sample_vld = v_mem[k];
                sample     = {s_mem[1][k], s_mem[0][k]};
            end else begin
                sample_vld = 1'(($urandom));
                sample     = (NCH*W)'({$urandom, $urandom});
            end
            start = rnd_start && (k < exp_end[0]) && ($urandom_range(0, 7) == 0);
            tick();
            if (done_e) begin
                ndone[0]++;
                if (got_done_k[0] < 0) got_done_k[0] = k;
            end
            if (done_n) begin
                ndone[1]++;
                if (got_done_k[1] < 0) got_done_k[1] = k;
            end
        end
        start = 1'b0;
        sample_vld = 1'b0;
        for (int e = 0; e < 2; e++) begin
            if (e == 0) begin
                set_o = settled_e; pass_o = pass_e; st_o = st_e; gc_o = gc_e;
                chk($sformatf("%s e%0d busy end", name, e), busy_e, 0);
            end else begin
                set_o = settled_n; pass_o = pass_n; st_o = st_n; gc_o = gc_n;
                chk($sformatf("%s e%0d busy end", name, e), busy_n, 0);
            end
            chk($sformatf("%s e%0d done cycle", name, e), got_done_k[e], exp_end[e]);
            chk($sformatf("%s e%0d done count", name, e), ndone[e], 1);
            for (int ch = 0; ch < NCH; ch++) begin
                chk($sformatf("%s e%0d settled%0d", name, e, ch), set_o[ch], exp_set[e][ch]);
                chk($sformatf("%s e%0d pass%0d", name, e, ch), pass_o[ch], exp_pass[e][ch]);
                chk($sformatf("%s e%0d st%0d", name, e, ch), st_o[ch*TW +: TW], exp_st[e][ch]);
                chk($sformatf("%s e%0d gc%0d", name, e, ch), gc_o[ch*GW +: GW], exp_gc[e][ch]);
            end
        end
    endtask

    task automatic fill_rand(input int t, input int tgt, input int tl);
        int off, sgn, r;
        for (int k = 0; k < t; k++) begin
            v_mem[k] = ($urandom_range(0, 9) < 8);
            for (int ch = 0; ch < NCH; ch++) begin
                r   = int'($urandom_range(0, 99));
                sgn = ($urandom_range(0, 1) == 1) ? 1 : -1;
                if (r < 60)      off = sgn * int'($urandom_range(0, tl));
                else if (r < 70) off = sgn * tl;
                else if (r < 80) off = sgn * (tl + 1);
                else             off = sgn * (tl + 1 + int'($urandom_range(0, 300)));
                s_mem[ch][k] = W'(tgt + off);
                if (r >= 97) s_mem[ch][k] = W'($urandom);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, t, d, tl;
        logic [W-1:0] tg;
        rst = 1'b1; start = 1'b0; abort = 1'b0; sample_vld = 1'b0;
        target = '0; tol = '0; dwell = '0; timeout = '0; sample = '0;
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();

        // Basic settle.
        for (int k = 0; k < 1000; k++) begin
            v_mem[k] = 1'b1;
            s_mem[0][k] = (k < 10) ? 16'sd500 : 16'sd100;
            s_mem[1][k] = 16'sd0;
        end
        do_run("basic", 1000, 4, 16'h0000, 16'd200, 1'b0);
        chk("basic done 14 after run", got_done_k[0] + 1, 14);
        chk("basic st ch0", st_e[TW-1:0], 10);
        chk("basic st ch1", st_e[2*TW-1:TW], 0);
        chk("basic pass", pass_e, 2'b11);

        // Dwell reset by a -201 sample.
        for (int k = 0; k < 30; k++) begin
            v_mem[k] = 1'b1;
            s_mem[0][k] = (k == 3) ? 16'hFF37 : 16'd0;
            s_mem[1][k] = 16'd1000;
        end
        do_run("dwellrst", 30, 4, 16'h0000, 16'd200, 1'b1);
        chk("dwellrst st ch0", st_n[TW-1:0], 4);

        // Post-settle glitches.
        for (int k = 0; k < 60; k++) begin
            v_mem[k] = 1'b1;
            s_mem[0][k] = (k == 5 || k == 6) ? 16'h0FFF : 16'd0;
            s_mem[1][k] = 16'd0;
        end
        do_run("glitch", 60, 3, 16'h0000, 16'd400, 1'b0);
        chk("glitch gc_n", gc_n[GW-1:0], 2);
        chk("glitch pass_n", pass_n[0], 0);
        chk("glitch settled_n", settled_n[0], 1);
        chk("glitch done at timeout", got_done_k[1] + 1, 60);

        // Timeout fail.
        for (int k = 0; k < 50; k++) begin
            v_mem[k] = 1'b1;
            s_mem[0][k] = 16'hF000;
            s_mem[1][k] = 16'hF000;
        end
        do_run("timeout", 50, 4, 16'h0000, 16'd200, 1'b1);
        chk("timeout done 50", got_done_k[0] + 1, 50);

        // Extremes: full-scale difference at maximum tolerance, then one LSB short.
        for (int k = 0; k < 10; k++) begin
            v_mem[k] = 1'b1;
            s_mem[0][k] = 16'h8000;
            s_mem[1][k] = 16'h8000;
        end
        do_run("extreme_in", 10, 1, 16'h7FFF, 16'hFFFF, 1'b0);
        chk("extreme_in settled", settled_e, 2'b11);
        for (int k = 0; k < 10; k++) begin
            s_mem[0][k] = 16'h7FFF;
            s_mem[1][k] = 16'h7FFF;
        end
        do_run("extreme_out", 10, 1, 16'h8000, 16'hFFFE, 1'b0);

        // timeout==0 acts as 1, dwell==0 acts as 1.
        v_mem[0] = 1'b1;
        s_mem[0][0] = 16'd0;
        s_mem[1][0] = 16'd7;
        do_run("tmo0", 0, 0, 16'h0000, 16'd5, 1'b0);

        // Randomized runs.
        for (int i = 0; i < 24; i++) begin
            t  = int'($urandom_range(1, 150));
            d  = int'($urandom_range(0, 6));
            tl = int'($urandom_range(0, 1000));
            tg = W'($urandom);
            fill_rand(t, int'($signed(tg)), tl);
            do_run($sformatf("rand%0d", i), t, d, tg, W'(tl), 1'b1);
        end

        // start+abort together in DONE: abort wins.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk_zero("abort_vs_start");

        // abort mid-RUN after a channel settled.
        arm(40, 3, 16'h0000, 16'd100);
        for (int k = 0; k < 6; k++) begin
            sample_vld = 1'b1;
            sample = {16'd5000, 16'd0};
            tick();
        end
        chk("abort pre settled", settled_n[0], 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_zero("abort");
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            cnt += int'(done_e) + int'(done_n);
        end
        chk("abort no done", cnt, 0);

        // abort on the final RUN cycle beats the timeout.
        arm(5, 2, 16'h0000, 16'd100);
        for (int k = 0; k < 5; k++) begin
            sample_vld = 1'b1;
            sample = {16'd5000, 16'd0};
            abort = (k == 4);
            tick();
        end
        abort = 1'b0;
        chk_zero("abort_vs_tmo");

        // rst mid-RUN.
        arm(40, 1, 16'h0000, 16'd100);
        for (int k = 0; k < 4; k++) begin
            sample_vld = 1'b1;
            sample = {16'd5000, 16'd0};
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("rst_mid");
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            cnt += int'(done_e) + int'(done_n) + int'(busy_e) + int'(busy_n);
        end
        chk("rst_mid idle after", cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/settle_mon.md
Name: settle_mon

Overview:
- Parametrised, multi-channel settling/convergence checker; the next generation of the bench-side "theta settles to zero" and "glitch-free transition" checks, built as a reusable sequential block.
- Watches NUM_CH signed sample streams, such as platform pitch or motor duty, against a programmed target band.
- Per channel, reports whether the stream settled within a timeout, when it settled, and how many out-of-band excursions followed settling.
- Sits beside the Segway model in system benches; also synthesisable for on-chip self-test.

Parameters:
NUM_CH, 2, number of monitored channels
WIDTH, 16, sample/target width (signed two's complement)
DWELL_W, 12, width of dwell-count input
TMO_W, 24, width of timeout input, elapsed counter and settle_time fields
GLT_W, 8, width of per-channel glitch counters (saturating)
MAX_GLITCH, 0, glitches tolerated before a settled channel fails
EARLY_EXIT, 1, 1 = finish as soon as all channels are settled; 0 = always run to timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; captures config and arms a run (accepted in IDLE/DONE only)
abort  in  1  pulse; returns to IDLE, no done pulse
target  in  WIDTH  signed target value
tol  in  WIDTH  unsigned band half-width
dwell  in  DWELL_W  consecutive in-band samples required to settle (0 treated as 1)
timeout  in  TMO_W  run length in clk cycles
sample  in  NUM_CH*WIDTH  packed samples, ch0 in LSBs
sample_vld  in  1  sample strobe, common to all channels
busy  out  1  high in ARM/RUN
done  out  1  one-cycle pulse on entering DONE
settled  out  NUM_CH  channel reached dwell criterion
pass  out  NUM_CH  settled[i] && glitch_cnt[i] <= MAX_GLITCH
settle_time  out  NUM_CH*TMO_W  elapsed count at start of each channel's winning dwell run
glitch_cnt  out  NUM_CH*GLT_W  post-settle out-of-band samples, saturating

Behaviour:
- Reset: clk and synchronous, active-high rst as stated above. On rst, all outputs and internal state are 0 and the FSM is in IDLE. rst mid-run discards the run; no done pulse.
- FSM IDLE -> ARM on start.
  - ARM lasts 1 cycle: latches target/tol/dwell/timeout, clears all per-channel state and the elapsed counter.
  - ARM -> RUN.
- In RUN:
  - elapsed increments every cycle, starting at 0 on the first RUN cycle.
  - RUN -> DONE when elapsed == timeout-1, or when (EARLY_EXIT && &settled) is true at the end of the cycle.
  - timeout==0 behaves as timeout==1.
- DONE holds all results. done pulses 1 cycle. DONE -> ARM on start.
- start while busy is ignored. abort in any state -> IDLE, results cleared; abort takes priority over start and over timeout on the same cycle.
- Band test, per channel:
  - diff = sample - target, computed in WIDTH+1 bits signed (no overflow).
  - mag = |diff| in WIDTH+1 bits.
  - in_band = mag <= {1'b0,tol}.
  - Only evaluated when sample_vld && RUN; samples outside RUN are ignored.
- Channel not yet settled:
  - in-band sample: if run_cnt==0, latch run_start=elapsed. run_cnt++.
  - settled set on the sample where run_cnt reaches max(dwell,1). settle_time <= run_start.
  - out-of-band sample: run_cnt <= 0.
  - run_cnt saturates; never wraps.
- Channel settled:
  - settled is sticky for the run.
  - each out-of-band sample increments glitch_cnt, saturating at all-ones.
  - in-band samples have no effect.
- A sample on the final RUN cycle is evaluated before the DONE transition, so a settle on that cycle counts.
- pass is combinational from the registered settled and glitch_cnt; it is meaningful in DONE and 0 in IDLE.
- settle_time is 0 for unsettled channels.

Test Plan:
- Basic settle:
  - Stimulus: WIDTH=16, target=0, tol=200, dwell=4, timeout=1000, EARLY_EXIT=1. ch0 sample_vld every cycle: 500 for 10 samples, then 100. ch1 = 0 from the start.
  - Required: ch1 settle_time=0; ch0 settle_time=10; done 14 cycles after RUN entry; pass=2'b11.
- Dwell reset:
  - Stimulus: ch0 in-band 3 samples, one sample of -201, then in-band; dwell=4.
  - Required: settle_time equals the elapsed value of the first sample after the -201.
- Post-settle glitch, MAX_GLITCH=0, EARLY_EXIT=0:
  - Stimulus: channel settles, then two samples of 16'sh0FFF with target=0, tol=400.
  - Required: glitch_cnt=2, settled=1, pass=0; done exactly at timeout.
- Timeout fail:
  - Stimulus: ch0 constant 16'shF000, target=0, tol=200, timeout=50.
  - Required: done 50 cycles after RUN entry; settled[0]=0; settle_time[0]=0; pass[0]=0.
- Extremes:
  - Stimulus: target=16'sh7FFF, sample=16'sh8000, tol=16'hFFFF.
  - Required: mag=65535, in_band=1, no overflow misflag.
- Control:
  - abort mid-RUN -> IDLE, no done, outputs 0.
  - start while RUN -> ignored.
  - rst asserted for 1 cycle mid-RUN -> all outputs 0 on the next cycle.
